// File: rtl/master_bridge_pkg.sv
// master_bridge_pkg: shared R-channel constants, descriptor field offsets and FSM states
package master_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int INFO_LEN_LSB = 2;
    localparam int INFO_ID_LSB  = 10;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

endpackage

// File: rtl/master_bridge_r_channel_ctrl.sv
// master_bridge_r_channel_ctrl: pops a descriptor, then streams len+1 FIFO beats onto AXI R
module master_bridge_r_channel_ctrl
    import master_bridge_pkg::*;
#(
    parameter int BEAT_SIZE  = 1024,
    parameter int ID_WIDTH   = 8,
    parameter int INFO_WIDTH = ID_WIDTH + 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_info_empty,
    input  logic [INFO_WIDTH-1:0] i_info,
    output logic                  o_info_inc,
    input  logic                  i_data_empty,
    input  logic [BEAT_SIZE-1:0]  i_data,
    output logic                  o_data_inc,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [BEAT_SIZE-1:0]  o_rdata,
    output logic [ID_WIDTH-1:0]   o_rid,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_busy
);

    state_e                state_q, state_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            resp_q, resp_d;
    logic                  rvalid_q, rvalid_d;
    logic [BEAT_SIZE-1:0]  rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  load;
    logic                  last_beat;

    // Next-state, pop strobes and output register stage; pops are gated by reset so no
    // descriptor or beat is lost while the FSM is being cleared
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        id_d       = id_q;
        len_d      = len_q;
        resp_d     = resp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        o_info_inc = 1'b0;
        o_data_inc = 1'b0;
        last_beat  = beat_cnt_q == len_q;
        load       = !i_rst && state_q == BURST && (!rvalid_q || i_rready) && !i_data_empty;
        if (state_q == IDLE) begin
            if (!i_rst && !i_info_empty) begin
                o_info_inc = 1'b1;
                id_d       = i_info[INFO_WIDTH-1:INFO_ID_LSB];
                len_d      = i_info[INFO_ID_LSB-1:INFO_LEN_LSB];
                resp_d     = i_info[INFO_LEN_LSB-1:0];
                beat_cnt_d = 8'd0;
                state_d    = BURST;
            end
        end else if (load) begin
            o_data_inc = 1'b1;
            rdata_d    = i_data;
            rid_d      = id_q;
            rresp_d    = resp_q;
            rlast_d    = last_beat;
            rvalid_d   = 1'b1;
            beat_cnt_d = beat_cnt_q + 8'd1;
            state_d    = last_beat ? IDLE : BURST;
        end
        if (rvalid_q && i_rready && !load) rvalid_d = 1'b0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= 8'd0;
            id_q       <= '0;
            len_q      <= 8'd0;
            resp_q     <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            id_q       <= id_d;
            len_q      <= len_d;
            resp_q     <= resp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;
    assign o_rid    = rid_q;
    assign o_rresp  = rresp_q;
    assign o_rlast  = rlast_q;
    assign o_busy   = state_q == BURST || rvalid_q;

endmodule

// File: tb/tb_master_bridge_r_channel_ctrl.sv
// tb_master_bridge_r_channel_ctrl: table vectors plus FIFO-model sequences for the R sequencer
module tb_master_bridge_r_channel_ctrl;

    localparam int BS = 1024;

    logic          clk = 1'b0;
    logic          i_rst, i_info_empty, o_info_inc, i_data_empty, o_data_inc;
    logic [17:0]   i_info;
    logic [BS-1:0] i_data, o_rdata;
    logic          o_rvalid, i_rready, o_rlast, o_busy;
    logic [7:0]    o_rid;
    logic [1:0]    o_rresp;

    master_bridge_r_channel_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_info_empty(i_info_empty), .i_info(i_info),
        .o_info_inc(o_info_inc), .i_data_empty(i_data_empty), .i_data(i_data),
        .o_data_inc(o_data_inc), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ie;
        logic [17:0] info;
        logic        de;
        logic [31:0] d;
        logic        rr;
        logic        e_ii, e_di, e_v;
        logic [31:0] e_d;
        logic [7:0]  e_id;
        logic [1:0]  e_r;
        logic        e_l, e_b;
    } vec_t;

    typedef struct {
        logic [BS-1:0] d;
        logic [7:0]    id;
        logic [1:0]    r;
        logic          l;
    } exp_t;

    vec_t          tbl [12];
    logic [17:0]   iq[$];
    logic [BS-1:0] dq[$];
    logic [BS-1:0] lq[$];
    exp_t          eq[$];
    int            checks = 0, failures = 0;
    int            cyc_n = 0, hs_cnt = 0, stall_at = -1, stall_left = 0, stall_seen = 0;
    int            hs_cyc [512];
    bit            sb_on = 1'b1, rst_v = 1'b0, stalled_prev = 1'b0, pi, pd;
    logic [BS-1:0] prev_d;
    logic          prev_l;

    function automatic logic [17:0] mk(input logic [7:0] id, input logic [7:0] len, input logic [1:0] r);
        return {id, len, r};
    endfunction

    task automatic chk(input string n, input logic [BS-1:0] a, input logic [BS-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic burst(input logic [7:0] id, input logic [7:0] len, input logic [1:0] r,
                         input logic [31:0] base, input int nd);
        logic [31:0] w;
        iq.push_back(mk(id, len, r));
        for (int i = 0; i <= int'(len); i++) begin
            w = base + 32'(i);
            if (i < nd) dq.push_back({32{w}}); else lq.push_back({32{w}});
            eq.push_back('{{32{w}}, id, r, i == int'(len)});
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        i_rst        = rst_v;
        i_info_empty = iq.size() == 0;
        i_info       = iq.size() != 0 ? iq[0] : '0;
        i_data_empty = dq.size() == 0;
        i_data       = dq.size() != 0 ? dq[0] : '0;
        i_rready     = !(o_rvalid && hs_cnt == stall_at && stall_left > 0);
        if (!i_rready) begin
            stall_left--;
            stall_seen++;
        end
        #1;
        if (stalled_prev) begin
            chk("stall_rdata", o_rdata, prev_d);
            chk("stall_rlast", o_rlast, prev_l);
        end
        stalled_prev = o_rvalid && !i_rready;
        if (stalled_prev) begin
            chk("stall_pop", o_data_inc, 0);
            prev_d = o_rdata;
            prev_l = o_rlast;
        end
        if (sb_on && o_rvalid && i_rready) begin
            if (eq.size() == 0) chk("extra_beat", 1, 0);
            else begin
                e = eq.pop_front();
                chk("beat_data", o_rdata, e.d);
                chk("beat_id", o_rid, e.id);
                chk("beat_resp", o_rresp, e.r);
                chk("beat_last", o_rlast, e.l);
                hs_cyc[hs_cnt] = cyc_n;
                hs_cnt++;
            end
        end
        pi = o_info_inc;
        pd = o_data_inc;
        @(posedge clk);
        if (pi) void'(iq.pop_front());
        if (pd) void'(dq.pop_front());
        cyc_n++;
    endtask

    task automatic run_done(input string n, input int maxc);
        int c = 0;
        while (eq.size() != 0 && c < maxc) begin
            cyc();
            c++;
        end
        chk({n, "_done"}, eq.size(), 0);
        repeat (3) cyc();
        chk({n, "_drained"}, dq.size() + iq.size(), 0);
    endtask

    initial begin
        i_rst = 1'b1; i_info_empty = 1'b1; i_info = '0; i_data_empty = 1'b1; i_data = '0; i_rready = 1'b1;
        tbl[0]  = '{1'b1, 1'b0, mk(8'h5A, 8'd0, 2'd0), 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, mk(8'h5A, 8'd0, 2'd0), 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 18'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 18'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 8'h5A, 2'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 18'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 8'h5A, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, mk(8'h01, 8'd1, 2'd0), 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 8'h5A, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, mk(8'h02, 8'd0, 2'd2), 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 8'h5A, 2'd0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, mk(8'h02, 8'd0, 2'd2), 1'b0, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 8'h01, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, mk(8'h02, 8'd0, 2'd2), 1'b0, 32'h33333333, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22222222, 8'h01, 2'd0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 18'h0, 1'b0, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222, 8'h01, 2'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 18'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33333333, 8'h02, 2'd2, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 18'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33333333, 8'h02, 2'd2, 1'b1, 1'b0};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            i_rst = tbl[i].rst; i_info_empty = tbl[i].ie; i_info = tbl[i].info;
            i_data_empty = tbl[i].de; i_data = {32{tbl[i].d}}; i_rready = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_info_inc", i), o_info_inc, tbl[i].e_ii);
            chk($sformatf("v%0d_data_inc", i), o_data_inc, tbl[i].e_di);
            chk($sformatf("v%0d_rvalid", i), o_rvalid, tbl[i].e_v);
            chk($sformatf("v%0d_rdata", i), o_rdata, {32{tbl[i].e_d}});
            chk($sformatf("v%0d_rid", i), o_rid, tbl[i].e_id);
            chk($sformatf("v%0d_rresp", i), o_rresp, tbl[i].e_r);
            chk($sformatf("v%0d_rlast", i), o_rlast, tbl[i].e_l);
            chk($sformatf("v%0d_busy", i), o_busy, tbl[i].e_b);
        end
        // full 256-beat burst at one beat per cycle
        hs_cnt = 0;
        burst(8'h33, 8'd255, 2'b00, 32'h1000, 256);
        run_done("full", 400);
        chk("full_count", hs_cnt, 256);
        chk("full_span", hs_cyc[255] - hs_cyc[0], 255);
        // backpressure on beat 1 for five cycles
        hs_cnt = 0; stall_at = 1; stall_left = 5; stall_seen = 0;
        burst(8'h44, 8'd3, 2'b11, 32'h2000, 4);
        run_done("bp", 40);
        chk("bp_stalls", stall_seen, 5);
        chk("bp_count", hs_cnt, 4);
        stall_at = -1;
        // underrun: beats 2..3 arrive late
        hs_cnt = 0;
        burst(8'h55, 8'd3, 2'b00, 32'h3000, 2);
        repeat (10) cyc();
        chk("ur_held", hs_cnt, 2);
        while (lq.size() != 0) dq.push_back(lq.pop_front());
        run_done("ur", 40);
        chk("ur_gap", (hs_cyc[2] - hs_cyc[1]) > 1, 1);
        // reset while beat 2 of a len=7 burst is on the bus
        hs_cnt = 0;
        burst(8'h66, 8'd7, 2'b10, 32'h4000, 8);
        for (int c = 0; c < 40 && hs_cnt < 2; c++) cyc();
        chk("rst_reached", hs_cnt, 2);
        sb_on = 1'b0; rst_v = 1'b1;
        cyc();
        rst_v = 1'b0;
        @(negedge clk);
        i_rst = 1'b0; i_info_empty = 1'b1; i_data_empty = dq.size() == 0; i_rready = 1'b1;
        i_data = dq.size() != 0 ? dq[0] : '0;
        #1;
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rid", o_rid, 0);
        chk("rst_rresp", o_rresp, 0);
        chk("rst_rlast", o_rlast, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data_inc", o_data_inc, 0);
        chk("rst_info_inc", o_info_inc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
